// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect-four turn sequencer.
package connect4_pkg;

  localparam int unsigned COLS_DEFAULT = 7;

  localparam int unsigned LRP_LEFT  = 2;
  localparam int unsigned LRP_RIGHT = 1;
  localparam int unsigned LRP_PUT   = 0;

  typedef enum logic [2:0] {
    IDLE,
    SELF_TURN,
    OPP_TURN,
    DROP,
    CHECK,
    OVER
  } turn_state_t;

  typedef enum logic [1:0] {
    P_NONE = 2'b00,
    P_SELF = 2'b01,
    P_OPP  = 2'b10
  } player_t;

  // Reduce simultaneous action edges to one: left > right > put.
  function automatic logic [2:0] first_action(input logic [2:0] edges);
    logic [2:0] sel;
    sel = '0;
    if (edges[LRP_LEFT]) begin
      sel[LRP_LEFT] = 1'b1;
    end else if (edges[LRP_RIGHT]) begin
      sel[LRP_RIGHT] = 1'b1;
    end else if (edges[LRP_PUT]) begin
      sel[LRP_PUT] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/tx_pulse_stretcher.sv
// Stretches a one-hot action trigger into a PULSE_LEN-cycle pulse on one of three lines.
module tx_pulse_stretcher
  import connect4_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] trig_i,
  output logic       tx_left_o,
  output logic       tx_right_o,
  output logic       tx_put_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] cnt_q;
  logic [2:0]    line_q;

  // Triggers arriving while a pulse is in flight are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (trig_i != 3'b000 && cnt_q == '0) begin
      cnt_q  <= CW'(PULSE_LEN);
      line_q <= trig_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        line_q <= '0;
      end
    end
  end

  assign busy_o     = (cnt_q != '0);
  assign tx_left_o  = line_q[LRP_LEFT];
  assign tx_right_o = line_q[LRP_RIGHT];
  assign tx_put_o   = line_q[LRP_PUT];

endmodule

// File: rtl/turn_controller.sv
// Connect-four game sequencer: turn ownership, shared cursor, drop handshake and verdict.
module turn_controller
  import connect4_pkg::*;
#(
  parameter int unsigned COLS      = COLS_DEFAULT,
  parameter int unsigned PULSE_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    first_self,
  input  logic [2:0]              lrp_self,
  input  logic [2:0]              lrp_opponent,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    my_turn,
  output logic                    drop_req,
  output logic [$clog2(COLS)-1:0] drop_col,
  output logic                    drop_self,
  input  logic                    drop_ack,
  input  logic                    drop_ok,
  input  logic                    result_valid,
  input  logic                    result_win,
  input  logic                    result_draw,
  output logic                    tx_left,
  output logic                    tx_right,
  output logic                    tx_put,
  output logic                    game_over,
  output logic [1:0]              winner
);

  localparam int unsigned CW = $clog2(COLS);
  localparam logic [CW-1:0] MID  = CW'(COLS / 2);
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);

  turn_state_t   state_q;
  player_t       winner_q;
  logic [CW-1:0] cursor_q, drop_col_q;
  logic          drop_req_q, drop_self_q, my_turn_q, game_over_q;
  logic [2:0]    self_prev_q, opp_prev_q;
  logic [2:0]    self_act, opp_act, turn_act, tx_trig;
  logic          tx_busy;

  function automatic logic [CW-1:0] step_cursor(input logic [CW-1:0] cur, input logic [2:0] act);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (act[LRP_LEFT]) begin
      nxt = (cur == '0) ? LAST : cur - CW'(1);
    end else if (act[LRP_RIGHT]) begin
      nxt = (cur == LAST) ? '0 : cur + CW'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    self_act = first_action(lrp_self & ~self_prev_q);
    opp_act  = first_action(lrp_opponent & ~opp_prev_q);
    turn_act = '0;
    tx_trig  = '0;
    if (state_q == SELF_TURN && !tx_busy) begin
      turn_act = self_act;
      tx_trig  = self_act;
    end else if (state_q == OPP_TURN) begin
      turn_act = opp_act;
    end
  end

  tx_pulse_stretcher #(
    .PULSE_LEN(PULSE_LEN)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .trig_i    (tx_trig),
    .tx_left_o (tx_left),
    .tx_right_o(tx_right),
    .tx_put_o  (tx_put),
    .busy_o    (tx_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cursor_q    <= MID;
      drop_col_q  <= '0;
      drop_req_q  <= 1'b0;
      drop_self_q <= 1'b0;
      my_turn_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= P_NONE;
      self_prev_q <= '0;
      opp_prev_q  <= '0;
    end else begin
      self_prev_q <= lrp_self;
      opp_prev_q  <= lrp_opponent;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q     <= first_self ? SELF_TURN : OPP_TURN;
            my_turn_q   <= first_self;
            game_over_q <= 1'b0;
            winner_q    <= P_NONE;
            cursor_q    <= MID;
          end
        end
        SELF_TURN, OPP_TURN: begin
          if (turn_act[LRP_PUT]) begin
            state_q     <= DROP;
            drop_req_q  <= 1'b1;
            drop_col_q  <= cursor_q;
            drop_self_q <= (state_q == SELF_TURN);
            my_turn_q   <= 1'b0;
          end else begin
            cursor_q <= step_cursor(cursor_q, turn_act);
          end
        end
        DROP: begin
          if (drop_ack) begin
            drop_req_q <= 1'b0;
            if (drop_ok) begin
              state_q <= CHECK;
            end else begin
              // Full column: same player tries again from the same cursor.
              state_q   <= drop_self_q ? SELF_TURN : OPP_TURN;
              my_turn_q <= drop_self_q;
            end
          end
        end
        CHECK: begin
          if (result_valid) begin
            if (result_win) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
              winner_q    <= drop_self_q ? P_SELF : P_OPP;
            end else if (result_draw) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
              winner_q    <= P_NONE;
            end else begin
              state_q   <= drop_self_q ? OPP_TURN : SELF_TURN;
              my_turn_q <= !drop_self_q;
              cursor_q  <= MID;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cursor_col = cursor_q;
  assign my_turn    = my_turn_q;
  assign drop_req   = drop_req_q;
  assign drop_col   = drop_col_q;
  assign drop_self  = drop_self_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a cycle model of the game rules.
module tb_turn_controller;

  localparam int COLS = 7;
  localparam int PLEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, first_self = 1'b0;
  logic [2:0] lrp_self = '0, lrp_opponent = '0;
  logic       drop_ack = 1'b0, drop_ok = 1'b0;
  logic       result_valid = 1'b0, result_win = 1'b0, result_draw = 1'b0;
  logic [2:0] cursor_col, drop_col;
  logic       my_turn, drop_req, drop_self, tx_left, tx_right, tx_put, game_over;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;

  turn_controller #(
    .COLS     (COLS),
    .PULSE_LEN(PLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .first_self  (first_self),
    .lrp_self    (lrp_self),
    .lrp_opponent(lrp_opponent),
    .cursor_col  (cursor_col),
    .my_turn     (my_turn),
    .drop_req    (drop_req),
    .drop_col    (drop_col),
    .drop_self   (drop_self),
    .drop_ack    (drop_ack),
    .drop_ok     (drop_ok),
    .result_valid(result_valid),
    .result_win  (result_win),
    .result_draw (result_draw),
    .tx_left     (tx_left),
    .tx_right    (tx_right),
    .tx_put      (tx_put),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: 0 idle, 1 self turn, 2 opp turn, 3 dropping, 4 awaiting verdict, 5 over.
  int m_st, m_cur, m_dcol, m_win, m_tx_rem, m_tx_kind;
  bit m_dreq, m_dself, m_ok = 0;
  logic [2:0] m_ps, m_po;

  // Returns 2 for left, 1 for right, 0 for put, -1 for no new press.
  function automatic int pick(input logic [2:0] lvl, input logic [2:0] prev);
    logic [2:0] e;
    e = lvl & ~prev;
    if (e[2]) return 2;
    if (e[1]) return 1;
    if (e[0]) return 0;
    return -1;
  endfunction

  task automatic m_apply(input int a, input bit mine);
    if (a == 2) m_cur = (m_cur + COLS - 1) % COLS;
    else if (a == 1) m_cur = (m_cur + 1) % COLS;
    else if (a == 0) begin
      m_st = 3; m_dreq = 1; m_dcol = m_cur; m_dself = mine;
    end
    if (mine && a >= 0) begin
      m_tx_rem = PLEN; m_tx_kind = a;
    end
  endtask

  always @(posedge clk) begin
    int as, ao;
    bit busy;
    if (rst) begin
      m_st = 0; m_cur = COLS / 2; m_dcol = 0; m_dreq = 0; m_dself = 0; m_win = 0;
      m_tx_rem = 0; m_tx_kind = 0; m_ps = '0; m_po = '0; m_ok = 1;
    end else if (m_ok) begin
      as = pick(lrp_self, m_ps);
      ao = pick(lrp_opponent, m_po);
      m_ps = lrp_self; m_po = lrp_opponent;
      busy = m_tx_rem > 0;
      if (m_tx_rem > 0) m_tx_rem--;
      case (m_st)
        0, 5: if (start) begin
          m_st = first_self ? 1 : 2; m_win = 0; m_cur = COLS / 2;
        end
        1: if (!busy) m_apply(as, 1);
        2: m_apply(ao, 0);
        3: if (drop_ack) begin
          m_dreq = 0;
          m_st = drop_ok ? 4 : (m_dself ? 1 : 2);
        end
        4: if (result_valid) begin
          if (result_win) begin m_st = 5; m_win = m_dself ? 1 : 2; end
          else if (result_draw) begin m_st = 5; m_win = 0; end
          else begin m_st = m_dself ? 2 : 1; m_cur = COLS / 2; end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_cursor", int'(cursor_col), m_cur);
      chk("m_my_turn", int'(my_turn), int'(m_st == 1));
      chk("m_game_over", int'(game_over), int'(m_st == 5));
      chk("m_drop_req", int'(drop_req), int'(m_dreq));
      chk("m_drop_col", int'(drop_col), m_dcol);
      chk("m_drop_self", int'(drop_self), int'(m_dself));
      chk("m_winner", int'(winner), m_win);
      chk("m_tx_left", int'(tx_left), int'(m_tx_rem > 0 && m_tx_kind == 2));
      chk("m_tx_right", int'(tx_right), int'(m_tx_rem > 0 && m_tx_kind == 1));
      chk("m_tx_put", int'(tx_put), int'(m_tx_rem > 0 && m_tx_kind == 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int exp_cur[4];
    exp_cur[0] = 2; exp_cur[1] = 1; exp_cur[2] = 0; exp_cur[3] = 6;

    rst = 1'b1;
    tick(2);
    chk("rst_cursor", int'(cursor_col), 3);
    chk("rst_drop_req", int'(drop_req), 0);
    rst = 1'b0;

    start = 1'b1; first_self = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_my_turn", int'(my_turn), 1);
    chk("start_cursor", int'(cursor_col), 3);
    chk("start_winner", int'(winner), 0);
    chk("start_tx", int'({tx_left, tx_right, tx_put}), 0);

    lrp_opponent = 3'b010;
    for (int i = 0; i < 4; i++) begin
      lrp_self = 3'b100;
      tick(1);
      chk("left_cursor", int'(cursor_col), exp_cur[i]);
      chk("left_tx", int'(tx_left), 1);
      lrp_self = 3'b000;
      tick(7);
    end
    lrp_opponent = 3'b000;

    lrp_self = 3'b001;
    tick(1);
    lrp_self = 3'b000;
    chk("put_drop_req", int'(drop_req), 1);
    chk("put_drop_col", int'(drop_col), 6);
    tick(2);
    chk("put_hold_req", int'(drop_req), 1);
    drop_ack = 1'b1; drop_ok = 1'b0;
    tick(1);
    drop_ack = 1'b0;
    chk("full_req", int'(drop_req), 0);
    chk("full_my_turn", int'(my_turn), 1);
    chk("full_cursor", int'(cursor_col), 6);
    tick(4);

    lrp_self = 3'b001;
    tick(1);
    lrp_self = 3'b000;
    drop_ack = 1'b1; drop_ok = 1'b1;
    tick(1);
    drop_ack = 1'b0;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    chk("switch_my_turn", int'(my_turn), 0);
    chk("switch_cursor", int'(cursor_col), 3);

    lrp_opponent = 3'b010;
    tick(8);
    lrp_opponent = 3'b000;
    chk("held_opp_cursor", int'(cursor_col), 4);
    tick(1);

    lrp_opponent = 3'b001;
    tick(1);
    lrp_opponent = 3'b000;
    chk("opp_drop_self", int'(drop_self), 0);
    drop_ack = 1'b1; drop_ok = 1'b1;
    tick(1);
    drop_ack = 1'b0;
    result_valid = 1'b1; result_win = 1'b1; result_draw = 1'b1;
    tick(1);
    result_valid = 1'b0; result_win = 1'b0; result_draw = 1'b0;
    chk("win_game_over", int'(game_over), 1);
    chk("win_winner", int'(winner), 2);
    lrp_self = 3'b100; lrp_opponent = 3'b010;
    tick(3);
    lrp_self = 3'b000; lrp_opponent = 3'b000;
    chk("over_cursor", int'(cursor_col), 4);
    start = 1'b1; first_self = 1'b0;
    tick(1);
    start = 1'b0;
    chk("restart_winner", int'(winner), 0);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_cursor", int'(cursor_col), 3);

    lrp_opponent = 3'b001;
    tick(1);
    lrp_opponent = 3'b000;
    chk("pre_rst_req", int'(drop_req), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_req", int'(drop_req), 0);
    chk("mid_rst_cursor", int'(cursor_col), 3);
    chk("mid_rst_tx", int'({tx_left, tx_right, tx_put}), 0);

    start = 1'b1; first_self = 1'b1;
    tick(1);
    start = 1'b0;
    lrp_self = 3'b011;
    tick(1);
    chk("prio_cursor", int'(cursor_col), 4);
    chk("prio_tx_right", int'(tx_right), 1);
    chk("prio_no_drop", int'(drop_req), 0);
    lrp_self = 3'b000;
    tick(5);
    lrp_self = 3'b001;
    tick(1);
    lrp_self = 3'b000;
    drop_ack = 1'b1; drop_ok = 1'b1;
    tick(1);
    drop_ack = 1'b0;
    result_valid = 1'b1; result_draw = 1'b1;
    tick(1);
    result_valid = 1'b0; result_draw = 1'b0;
    chk("draw_game_over", int'(game_over), 1);
    chk("draw_winner", int'(winner), 0);
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
